// File: rtl/stack_mem_unit.sv
// stack_mem_unit: memory-stage stack / data-memory sequencer.
// Owns the stack pointer, a word-addressed data RAM and the frozen CCR.
// It runs the two-cycle CALL / INT / RET / RTI sequences and rebuilds
// 32-bit return PCs from two popped 16-bit halves. Every output is
// registered, so each result appears in the cycle after its operation.
module stack_mem_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        push_pop,
    input  logic [1:0]        call_phase,
    input  logic [1:0]        int_phase,
    input  logic [1:0]        ret_phase,
    input  logic              is_rti,
    input  logic              is_push,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic [31:0]       pc,
    input  logic [2:0]        ccr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              pc_load,
    output logic [31:0]       pc_target,
    output logic              ccr_restore,
    output logic [2:0]        ccr_frozen,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_exc,
    output logic              seq_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALL2 = 2'd1,
        S_INT2  = 2'd2,
        S_RET2  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] SP_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] SP_ZERO = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              pc_load_q, pc_load_d;
    logic [31:0]       pc_target_q, pc_target_d;
    logic              ccr_restore_q, ccr_restore_d;
    logic [2:0]        ccr_frozen_q, ccr_frozen_d;
    logic              stack_exc_q, stack_exc_d;
    logic              seq_err_q, seq_err_d;
    logic [DATA_W-1:0] pc_hi_q, pc_hi_d;

    logic              do_push, do_pop, push_ok, pop_ok, int_entry, stray_phase2;
    logic [ADDR_W-1:0] sp_inc, sp_dec, mem_addr;
    logic [DATA_W-1:0] pop_word, ld_word, push_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign do_push   = (push_pop == 2'b01);
    assign do_pop    = (push_pop == 2'b11);
    assign push_ok   = do_push && (sp_q != SP_ZERO);
    assign pop_ok    = do_pop && (sp_q != SP_RESET);
    assign sp_inc    = sp_q + SP_ONE;
    assign sp_dec    = sp_q - SP_ONE;
    assign mem_addr  = alu_out[ADDR_W-1:0];
    assign pop_word  = mem_q[sp_inc];
    assign ld_word   = mem_q[mem_addr];
    // Interrupt entry is the push whose data source is the low PC half.
    assign int_entry = do_push && (int_phase == 2'b11) &&
                       (call_phase != 2'b11) && (call_phase != 2'b01);
    assign stray_phase2 = (call_phase == 2'b01) || (int_phase == 2'b01) ||
                          (ret_phase == 2'b01);

    // Select the word a push stores, highest-priority source first.
    always_comb begin
        push_data = '0;
        if (call_phase == 2'b11) begin
            push_data = DATA_W'(pc[15:0] + 16'd1);
        end else if ((call_phase == 2'b01) || (int_phase == 2'b01)) begin
            push_data = DATA_W'(pc[31:16]);
        end else if (int_phase == 2'b11) begin
            push_data = DATA_W'(pc[15:0]);
        end else if (is_push) begin
            push_data = alu_out;
        end
    end

    // Decode the cycle's memory/stack op and advance the sequence FSM.
    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        pc_load_d     = 1'b0;
        pc_target_d   = pc_target_q;
        ccr_restore_d = 1'b0;
        ccr_frozen_d  = ccr_frozen_q;
        stack_exc_d   = 1'b0;
        seq_err_d     = 1'b0;
        pc_hi_d       = pc_hi_q;
        mem_we        = 1'b0;
        mem_waddr     = sp_q;
        mem_wdata     = push_data;

        if (do_push) begin
            if (push_ok) begin
                mem_we = 1'b1;
                sp_d   = sp_dec;
            end else begin
                stack_exc_d = 1'b1;
            end
            if (int_entry) begin
                ccr_frozen_d = ccr;
            end
        end else if (do_pop) begin
            if (pop_ok) begin
                sp_d       = sp_inc;
                rd_data_d  = pop_word;
                rd_valid_d = 1'b1;
            end else begin
                stack_exc_d = 1'b1;
            end
        end else begin
            if (mem_write) begin
                mem_we    = 1'b1;
                mem_waddr = mem_addr;
                mem_wdata = store_data;
            end
            if (mem_read) begin
                rd_data_d  = ld_word;
                rd_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (stray_phase2) begin
                    seq_err_d = 1'b1;
                end
                if (do_push && (call_phase == 2'b11)) begin
                    state_d = S_CALL2;
                end else if (do_push && (int_phase == 2'b11)) begin
                    state_d = S_INT2;
                end else if (do_pop && (ret_phase == 2'b11)) begin
                    state_d = S_RET2;
                    pc_hi_d = pop_ok ? pop_word : '0;
                end
            end
            S_CALL2: begin
                if (!(do_push && (call_phase == 2'b01))) begin
                    seq_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_INT2: begin
                if (!(do_push && (int_phase == 2'b01))) begin
                    seq_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_RET2: begin
                if (do_pop && (ret_phase == 2'b01)) begin
                    // An underflowed low-half pop leaves nothing to jump to.
                    if (pop_ok) begin
                        pc_load_d     = 1'b1;
                        pc_target_d   = {pc_hi_q, pop_word};
                        ccr_restore_d = is_rti;
                    end
                end else begin
                    seq_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            sp_q          <= SP_RESET;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_target_q   <= '0;
            ccr_restore_q <= 1'b0;
            ccr_frozen_q  <= '0;
            stack_exc_q   <= 1'b0;
            seq_err_q     <= 1'b0;
            pc_hi_q       <= '0;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            pc_load_q     <= pc_load_d;
            pc_target_q   <= pc_target_d;
            ccr_restore_q <= ccr_restore_d;
            ccr_frozen_q  <= ccr_frozen_d;
            stack_exc_q   <= stack_exc_d;
            seq_err_q     <= seq_err_d;
            pc_hi_q       <= pc_hi_d;
        end
    end

    // Data RAM write port; contents survive reset, but no write lands during it.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign pc_load     = pc_load_q;
    assign pc_target   = pc_target_q;
    assign ccr_restore = ccr_restore_q;
    assign ccr_frozen  = ccr_frozen_q;
    assign sp          = sp_q;
    assign stack_exc   = stack_exc_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_stack_mem_unit.sv
// Testbench for stack_mem_unit: directed scenarios plus a randomized run
// against a behavioural stack / memory / sequence model.
module tb_stack_mem_unit;

    localparam int SPR = 2047;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  push_pop, call_phase, int_phase, ret_phase;
    logic        is_rti, is_push, mem_read, mem_write;
    logic [15:0] alu_out, store_data;
    logic [31:0] pc;
    logic [2:0]  ccr;
    logic [15:0] rd_data;
    logic        rd_valid, pc_load, ccr_restore, stack_exc, seq_err;
    logic [31:0] pc_target;
    logic [2:0]  ccr_frozen;
    logic [10:0] sp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stack_mem_unit dut (
        .clk(clk), .rst(rst), .push_pop(push_pop), .call_phase(call_phase),
        .int_phase(int_phase), .ret_phase(ret_phase), .is_rti(is_rti),
        .is_push(is_push), .mem_read(mem_read), .mem_write(mem_write),
        .alu_out(alu_out), .store_data(store_data), .pc(pc), .ccr(ccr),
        .rd_data(rd_data), .rd_valid(rd_valid), .pc_load(pc_load),
        .pc_target(pc_target), .ccr_restore(ccr_restore),
        .ccr_frozen(ccr_frozen), .sp(sp), .stack_exc(stack_exc),
        .seq_err(seq_err)
    );

    typedef struct {
        logic [1:0]  pp, cph, iph, rph;
        logic        rti, ip, mr, mw;
        logic [15:0] alu, sd;
        logic [31:0] pcv;
        logic [2:0]  ccrv;
    } stim_t;

    // Behavioural model state
    logic [15:0] m_mem [0:2047];
    bit          m_known [0:2047];
    int          m_sp;
    int          m_pend;       // 0 none, 1 call, 2 int, 3 ret awaiting second cycle
    logic [15:0] m_hi;
    bit          m_hi_known;
    logic [15:0] e_rd_data;
    bit          e_rd_known, e_rd_valid, e_pc_load, e_ccr_restore, e_stack_exc, e_seq_err;
    logic [31:0] e_pc_target;
    bit          e_tgt_known;
    logic [2:0]  e_ccr_frozen;

    task automatic idle_in();
        push_pop = 2'b00; call_phase = 2'b00; int_phase = 2'b00; ret_phase = 2'b00;
        is_rti = 1'b0; is_push = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        alu_out = 16'h0; store_data = 16'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input stim_t s);
        push_pop = s.pp; call_phase = s.cph; int_phase = s.iph; ret_phase = s.rph;
        is_rti = s.rti; is_push = s.ip; mem_read = s.mr; mem_write = s.mw;
        alu_out = s.alu; store_data = s.sd; pc = s.pcv; ccr = s.ccrv;
    endtask

    // Expected effect of the inputs currently applied, from the stack rules.
    task automatic model_step();
        bit psh, pop, popped, wk;
        logic [15:0] w, d;
        int a;
        psh = (push_pop == 2'b01);
        pop = (push_pop == 2'b11);
        popped = 0; wk = 0; w = 16'h0;
        e_rd_valid = 0; e_pc_load = 0; e_ccr_restore = 0; e_stack_exc = 0; e_seq_err = 0;
        if (psh) begin
            if (call_phase == 2'b11) d = pc[15:0] + 16'd1;
            else if (call_phase == 2'b01 || int_phase == 2'b01) d = pc[31:16];
            else if (int_phase == 2'b11) d = pc[15:0];
            else d = is_push ? alu_out : 16'h0;
            if (int_phase == 2'b11 && call_phase != 2'b11 && call_phase != 2'b01) e_ccr_frozen = ccr;
            if (m_sp == 0) e_stack_exc = 1;
            else begin m_mem[m_sp] = d; m_known[m_sp] = 1; m_sp = m_sp - 1; end
        end else if (pop) begin
            if (m_sp == SPR) e_stack_exc = 1;
            else begin
                m_sp = m_sp + 1; w = m_mem[m_sp]; wk = m_known[m_sp]; popped = 1;
                e_rd_valid = 1; e_rd_data = w; e_rd_known = wk;
            end
        end else begin
            a = int'(alu_out[10:0]);
            if (mem_write) begin m_mem[a] = store_data; m_known[a] = 1; end
            if (mem_read) begin e_rd_valid = 1; e_rd_data = m_mem[a]; e_rd_known = m_known[a]; end
        end
        case (m_pend)
            0: begin
                if (call_phase == 2'b01 || int_phase == 2'b01 || ret_phase == 2'b01) e_seq_err = 1;
                if (psh && call_phase == 2'b11) m_pend = 1;
                else if (psh && int_phase == 2'b11) m_pend = 2;
                else if (pop && ret_phase == 2'b11) begin
                    m_pend = 3; m_hi = popped ? w : 16'h0; m_hi_known = popped ? wk : 1'b1;
                end
            end
            1: begin if (!(psh && call_phase == 2'b01)) e_seq_err = 1; m_pend = 0; end
            2: begin if (!(psh && int_phase == 2'b01)) e_seq_err = 1; m_pend = 0; end
            default: begin
                if (pop && ret_phase == 2'b01) begin
                    if (popped) begin
                        e_pc_load = 1; e_pc_target = {m_hi, w};
                        e_tgt_known = m_hi_known && wk; e_ccr_restore = is_rti;
                    end
                end else e_seq_err = 1;
                m_pend = 0;
            end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b0; idle_in(); pc = 32'h0; ccr = 3'b000;
        tick(); tick();
        checks++; if (sp !== 11'h7FF) begin failures++; $display("FAIL reset_sp got=%h exp=7ff", sp); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (pc_load !== 1'b0) begin failures++; $display("FAIL reset_pc_load got=%b exp=0", pc_load); end
        checks++; if (pc_target !== 32'h0) begin failures++; $display("FAIL reset_pc_target got=%h exp=0", pc_target); end
        checks++; if (ccr_restore !== 1'b0) begin failures++; $display("FAIL reset_ccr_restore got=%b exp=0", ccr_restore); end
        checks++; if (ccr_frozen !== 3'b000) begin failures++; $display("FAIL reset_ccr_frozen got=%b exp=000", ccr_frozen); end
        checks++; if (stack_exc !== 1'b0) begin failures++; $display("FAIL reset_stack_exc got=%b exp=0", stack_exc); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
        rst = 1'b1;
    endtask

    task automatic test_push_pop();
        idle_in(); push_pop = 2'b01; is_push = 1'b1; alu_out = 16'hBEEF;
        tick();
        checks++; if (sp !== 11'h7FE) begin failures++; $display("FAIL push_sp got=%h exp=7fe", sp); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL push_rd_valid got=%b exp=0", rd_valid); end
        idle_in(); push_pop = 2'b11;
        tick();
        checks++; if (sp !== 11'h7FF) begin failures++; $display("FAIL pop_sp got=%h exp=7ff", sp); end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL pop_rd_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== 16'hBEEF) begin failures++; $display("FAIL pop_rd_data got=%h exp=beef", rd_data); end
        idle_in(); tick();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL pop_rd_valid_pulse got=%b exp=0", rd_valid); end
    endtask

    task automatic test_call_ret();
        idle_in(); pc = 32'h0001_0010; push_pop = 2'b01; call_phase = 2'b11;
        tick();
        idle_in(); push_pop = 2'b01; call_phase = 2'b01;
        tick();
        checks++; if (sp !== 11'h7FD) begin failures++; $display("FAIL call_sp got=%h exp=7fd", sp); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL call_seq_err got=%b exp=0", seq_err); end
        idle_in(); push_pop = 2'b11; ret_phase = 2'b11;
        tick();
        checks++; if (rd_data !== 16'h0001) begin failures++; $display("FAIL ret_hi_word got=%h exp=0001", rd_data); end
        checks++; if (pc_load !== 1'b0) begin failures++; $display("FAIL ret_early_pc_load got=%b exp=0", pc_load); end
        idle_in(); push_pop = 2'b11; ret_phase = 2'b01;
        tick();
        checks++; if (rd_data !== 16'h0011) begin failures++; $display("FAIL ret_lo_word got=%h exp=0011", rd_data); end
        checks++; if (pc_load !== 1'b1) begin failures++; $display("FAIL ret_pc_load got=%b exp=1", pc_load); end
        checks++; if (pc_target !== 32'h0001_0011) begin failures++; $display("FAIL ret_pc_target got=%h exp=00010011", pc_target); end
        checks++; if (ccr_restore !== 1'b0) begin failures++; $display("FAIL ret_ccr_restore got=%b exp=0", ccr_restore); end
        checks++; if (sp !== 11'h7FF) begin failures++; $display("FAIL ret_sp got=%h exp=7ff", sp); end
        idle_in(); tick();
        checks++; if (pc_load !== 1'b0) begin failures++; $display("FAIL ret_pc_load_pulse got=%b exp=0", pc_load); end
    endtask

    task automatic test_int_rti();
        idle_in(); pc = 32'h0000_0040; ccr = 3'b101; push_pop = 2'b01; int_phase = 2'b11;
        tick();
        checks++; if (ccr_frozen !== 3'b101) begin failures++; $display("FAIL int_ccr_frozen got=%b exp=101", ccr_frozen); end
        idle_in(); ccr = 3'b010; push_pop = 2'b01; int_phase = 2'b01;
        tick();
        idle_in(); ccr = 3'b000; push_pop = 2'b11; ret_phase = 2'b11; is_rti = 1'b1;
        tick();
        idle_in(); push_pop = 2'b11; ret_phase = 2'b01; is_rti = 1'b1;
        tick();
        checks++; if (pc_load !== 1'b1) begin failures++; $display("FAIL rti_pc_load got=%b exp=1", pc_load); end
        checks++; if (ccr_restore !== 1'b1) begin failures++; $display("FAIL rti_ccr_restore got=%b exp=1", ccr_restore); end
        checks++; if (pc_target !== 32'h0000_0040) begin failures++; $display("FAIL rti_pc_target got=%h exp=00000040", pc_target); end
        checks++; if (ccr_frozen !== 3'b101) begin failures++; $display("FAIL rti_ccr_frozen got=%b exp=101", ccr_frozen); end
        idle_in(); tick();
        checks++; if (ccr_restore !== 1'b0) begin failures++; $display("FAIL rti_ccr_restore_pulse got=%b exp=0", ccr_restore); end
    endtask

    task automatic test_ldd_std();
        idle_in(); mem_write = 1'b1; alu_out = 16'h0020; store_data = 16'h1234;
        tick();
        idle_in(); mem_read = 1'b1; alu_out = 16'h0020;
        tick();
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL ldd_rd_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== 16'h1234) begin failures++; $display("FAIL ldd_rd_data got=%h exp=1234", rd_data); end
        idle_in(); push_pop = 2'b01; is_push = 1'b1; mem_write = 1'b1; alu_out = 16'h0020; store_data = 16'hDEAD;
        tick();
        checks++; if (sp !== 11'h7FE) begin failures++; $display("FAIL push_std_sp got=%h exp=7fe", sp); end
        idle_in(); mem_read = 1'b1; alu_out = 16'hF820;   // upper bits ignored as address
        tick();
        checks++; if (rd_data !== 16'h1234) begin failures++; $display("FAIL push_std_ram got=%h exp=1234", rd_data); end
        idle_in(); push_pop = 2'b11;
        tick();
        checks++; if (rd_data !== 16'h0020) begin failures++; $display("FAIL push_std_pop got=%h exp=0020", rd_data); end
    endtask

    task automatic test_boundaries();
        idle_in(); push_pop = 2'b11;
        tick();
        checks++; if (stack_exc !== 1'b1) begin failures++; $display("FAIL underflow_exc got=%b exp=1", stack_exc); end
        checks++; if (sp !== 11'h7FF) begin failures++; $display("FAIL underflow_sp got=%h exp=7ff", sp); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL underflow_rd_valid got=%b exp=0", rd_valid); end
        idle_in(); mem_write = 1'b1; alu_out = 16'h0000; store_data = 16'h5A5A;
        tick();
        checks++; if (stack_exc !== 1'b0) begin failures++; $display("FAIL underflow_exc_pulse got=%b exp=0", stack_exc); end
        for (int i = 0; i < SPR; i++) begin
            idle_in(); push_pop = 2'b01; is_push = 1'b1; alu_out = 16'(i);
            tick();
        end
        checks++; if (sp !== 11'h000) begin failures++; $display("FAIL fill_sp got=%h exp=000", sp); end
        idle_in(); push_pop = 2'b01; is_push = 1'b1; alu_out = 16'hAAAA;
        tick();
        checks++; if (stack_exc !== 1'b1) begin failures++; $display("FAIL overflow_exc got=%b exp=1", stack_exc); end
        checks++; if (sp !== 11'h000) begin failures++; $display("FAIL overflow_sp got=%h exp=000", sp); end
        idle_in(); mem_read = 1'b1; alu_out = 16'h0000;
        tick();
        checks++; if (rd_data !== 16'h5A5A) begin failures++; $display("FAIL overflow_ram0 got=%h exp=5a5a", rd_data); end
        idle_in(); push_pop = 2'b11;
        tick();
        checks++; if (rd_data !== 16'h07FE) begin failures++; $display("FAIL overflow_top_word got=%h exp=07fe", rd_data); end
        checks++; if (sp !== 11'h001) begin failures++; $display("FAIL overflow_pop_sp got=%h exp=001", sp); end
        rst = 1'b0; idle_in(); tick(); rst = 1'b1;
    endtask

    task automatic test_seq_err();
        idle_in(); pc = 32'h0003_0007; push_pop = 2'b01; call_phase = 2'b11;
        tick();
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL seq_first_err got=%b exp=0", seq_err); end
        idle_in(); push_pop = 2'b11;
        tick();
        checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL seq_broken_err got=%b exp=1", seq_err); end
        checks++; if (sp !== 11'h7FF) begin failures++; $display("FAIL seq_broken_sp got=%h exp=7ff", sp); end
        checks++; if (rd_data !== 16'h0008) begin failures++; $display("FAIL seq_broken_pop got=%h exp=0008", rd_data); end
        idle_in(); push_pop = 2'b01; call_phase = 2'b01;
        tick();
        checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL seq_stray_err got=%b exp=1", seq_err); end
        checks++; if (sp !== 11'h7FE) begin failures++; $display("FAIL seq_stray_sp got=%h exp=7fe", sp); end
        idle_in(); push_pop = 2'b11;
        tick();
        checks++; if (rd_data !== 16'h0003) begin failures++; $display("FAIL seq_stray_word got=%h exp=0003", rd_data); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL seq_clear_err got=%b exp=0", seq_err); end
    endtask

    task automatic test_reset_mid();
        idle_in(); pc = 32'h0002_0005; push_pop = 2'b01; call_phase = 2'b11;
        tick();
        idle_in(); push_pop = 2'b01; call_phase = 2'b01;
        tick();
        idle_in(); push_pop = 2'b11; ret_phase = 2'b11;
        tick();
        idle_in(); push_pop = 2'b11; ret_phase = 2'b01; rst = 1'b0;
        tick();
        rst = 1'b1; idle_in();
        checks++; if (pc_load !== 1'b0) begin failures++; $display("FAIL rstmid_pc_load got=%b exp=0", pc_load); end
        checks++; if (sp !== 11'h7FF) begin failures++; $display("FAIL rstmid_sp got=%h exp=7ff", sp); end
        push_pop = 2'b11; ret_phase = 2'b01;
        tick();
        checks++; if (pc_load !== 1'b0) begin failures++; $display("FAIL rstmid_after_pc_load got=%b exp=0", pc_load); end
        checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL rstmid_after_seq_err got=%b exp=1", seq_err); end
        checks++; if (stack_exc !== 1'b1) begin failures++; $display("FAIL rstmid_after_exc got=%b exp=1", stack_exc); end
        idle_in(); tick();
    endtask

    task automatic test_random();
        stim_t q[$];
        stim_t s, z;
        int k;
        logic [31:0] rpc;
        z = '{pp: 2'b00, cph: 2'b00, iph: 2'b00, rph: 2'b00, rti: 1'b0, ip: 1'b0,
              mr: 1'b0, mw: 1'b0, alu: 16'h0, sd: 16'h0, pcv: 32'h0, ccrv: 3'b000};
        for (int n = 0; n < 160; n++) begin
            k = $urandom_range(0, 9);
            rpc = $urandom;
            s = z; s.pcv = rpc;
            case (k)
                0: begin s.pp = 2'b01; s.ip = 1'b1; s.alu = 16'($urandom); q.push_back(s); end
                1: begin s.pp = 2'b11; q.push_back(s); end
                2: begin s.pp = 2'b01; s.cph = 2'b11; q.push_back(s); s.cph = 2'b01; q.push_back(s); end
                3: begin s.ccrv = 3'($urandom); s.pp = 2'b01; s.iph = 2'b11; q.push_back(s);
                          s.iph = 2'b01; q.push_back(s); end
                4: begin s.rti = 1'($urandom); s.pp = 2'b11; s.rph = 2'b11; q.push_back(s);
                          s.rph = 2'b01; q.push_back(s); end
                5: begin s.mw = 1'b1; s.alu = {5'($urandom), 11'($urandom_range(0, 63))};
                          s.sd = 16'($urandom); q.push_back(s); end
                6: begin s.mr = 1'b1; s.alu = {5'($urandom), 11'($urandom_range(0, 63))}; q.push_back(s); end
                7: begin s.pp = 2'b01; s.cph = 2'b11; q.push_back(s);
                          s = z; s.pp = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00; q.push_back(s); end
                8: begin s.pp = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
                          if (s.pp == 2'b11) s.rph = 2'b01; else s.iph = 2'b01; q.push_back(s); end
                default: q.push_back(s);
            endcase
        end
        rst = 1'b0; idle_in(); tick(); rst = 1'b1;
        m_sp = SPR; m_pend = 0; m_hi = 16'h0; m_hi_known = 1;
        for (int i = 0; i < 2048; i++) m_known[i] = 0;
        e_rd_data = 16'h0; e_rd_known = 1; e_pc_target = 32'h0; e_tgt_known = 1; e_ccr_frozen = 3'b000;
        foreach (q[i]) begin
            apply(q[i]);
            model_step();
            tick();
            checks++; if (sp !== 11'(m_sp)) begin failures++; $display("FAIL rnd_sp[%0d] got=%h exp=%h", i, sp, 11'(m_sp)); end
            checks++; if (rd_valid !== e_rd_valid) begin failures++; $display("FAIL rnd_rd_valid[%0d] got=%b exp=%b", i, rd_valid, e_rd_valid); end
            if (e_rd_valid && e_rd_known) begin
                checks++; if (rd_data !== e_rd_data) begin failures++; $display("FAIL rnd_rd_data[%0d] got=%h exp=%h", i, rd_data, e_rd_data); end
            end
            checks++; if (pc_load !== e_pc_load) begin failures++; $display("FAIL rnd_pc_load[%0d] got=%b exp=%b", i, pc_load, e_pc_load); end
            if (e_pc_load && e_tgt_known) begin
                checks++; if (pc_target !== e_pc_target) begin failures++; $display("FAIL rnd_pc_target[%0d] got=%h exp=%h", i, pc_target, e_pc_target); end
            end
            checks++; if (ccr_restore !== e_ccr_restore) begin failures++; $display("FAIL rnd_ccr_restore[%0d] got=%b exp=%b", i, ccr_restore, e_ccr_restore); end
            checks++; if (ccr_frozen !== e_ccr_frozen) begin failures++; $display("FAIL rnd_ccr_frozen[%0d] got=%b exp=%b", i, ccr_frozen, e_ccr_frozen); end
            checks++; if (stack_exc !== e_stack_exc) begin failures++; $display("FAIL rnd_stack_exc[%0d] got=%b exp=%b", i, stack_exc, e_stack_exc); end
            checks++; if (seq_err !== e_seq_err) begin failures++; $display("FAIL rnd_seq_err[%0d] got=%b exp=%b", i, seq_err, e_seq_err); end
        end
        idle_in(); tick();
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_call_ret();
        test_int_rti();
        test_ldd_std();
        test_boundaries();
        test_seq_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_mem_unit.md
Name: stack_mem_unit

Overview:
Memory-stage stack and data-memory sequencer that executes the push/pop, call, ret, interrupt and RTI sequences issued by decode. It owns the stack pointer, a word-addressed data RAM, the frozen CCR, and reassembly of 32-bit return PCs from two popped 16-bit halves. It sits after the E2M buffer. It feeds the M2W buffer, the PC mux (pc_load) and the CCR (ccr_restore).

Parameters:
DATA_W, 16, memory word / register width
ADDR_W, 11, data RAM address width (2^ADDR_W words)
SP_RESET, 2^ADDR_W-1, stack pointer value after reset (stack grows down)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
push_pop  in  2  00 none, 01 push, 11 pop, 10 treated as none
call_phase  in  2  11 first call cycle, 01 second, else none
int_phase  in  2  11 first interrupt cycle, 01 second, else none
ret_phase  in  2  11 first ret/rti cycle, 01 second, else none
is_rti  in  1  qualifies ret_phase as RTI
is_push  in  1  PUSH instruction: push data = alu_out
mem_read  in  1  LDD / pop read enable
mem_write  in  1  STD write enable
alu_out  in  DATA_W  LDD/STD address (low ADDR_W bits) or PUSH data
store_data  in  DATA_W  STD write data
pc  in  32  PC of the instruction in this stage
ccr  in  3  current flags {C,N,Z}
rd_data  out  DATA_W  registered read data to M2W
rd_valid  out  1  rd_data valid (1-cycle pulse)
pc_load  out  1  load pc_target into PC (1-cycle pulse)
pc_target  out  32  reassembled return address
ccr_restore  out  1  restore ccr_frozen into CCR (1-cycle pulse)
ccr_frozen  out  3  CCR saved at interrupt entry
sp  out  ADDR_W  current stack pointer
stack_exc  out  1  overflow/underflow pulse
seq_err  out  1  broken two-cycle sequence pulse

Behaviour:
- Reset (rst=0 at clk edge): sp=SP_RESET; FSM=IDLE; rd_data=0, rd_valid=0, pc_load=0, pc_target=0, ccr_restore=0, ccr_frozen=0, stack_exc=0, seq_err=0; the pc_hi latch is cleared. RAM contents are not reset. A reset in the middle of a sequence aborts it with no pc_load.
- Push (push_pop=01): the write uses the current sp, then sp<=sp-1 (post-decrement). Data source, by priority:
  - call_phase=11: pc[15:0]+1.
  - call_phase=01 or int_phase=01: pc[31:16].
  - int_phase=11: pc[15:0] unchanged; ccr_frozen<=ccr in the same cycle.
  - is_push: alu_out.
- Pop (push_pop=11): sp<=sp+1, then read RAM[sp+1]. rd_data and rd_valid are registered, so they are visible in the next cycle.
- Stack boundaries:
  - Push with sp==0: write suppressed, sp unchanged, stack_exc pulses.
  - Pop with sp==SP_RESET: read suppressed, sp unchanged, rd_valid=0, stack_exc pulses.
- LDD (mem_read, push_pop=00): rd_data<=RAM[alu_out[ADDR_W-1:0]], rd_valid=1 next cycle.
- STD (mem_write, push_pop=00): RAM[alu_out]<=store_data.
- If push_pop!=00 and mem_write/mem_read are also asserted, the stack op wins and the LDD/STD is ignored.
- FSM states: IDLE, CALL2, INT2, RET2.
  - IDLE->CALL2 on push with call_phase=11.
  - IDLE->INT2 on push with int_phase=11.
  - IDLE->RET2 on pop with ret_phase=11; pc_hi<=popped word.
  - CALL2 and INT2 expect a push with the matching phase=01, then go to IDLE.
  - RET2 expects a pop with ret_phase=01. In the following cycle pc_target={pc_hi, popped word} and pc_load=1 for one cycle. If is_rti was set at the RET2 pop, ccr_restore=1 in the same cycle as pc_load. FSM then goes to IDLE.
  - In CALL2, INT2 or RET2, any other input:
    - seq_err pulses and the FSM returns to IDLE.
    - The current cycle's op still executes as decoded.
    - No pc_load is produced.
  - A phase=01 received in IDLE: seq_err pulses. The push/pop is still executed.
- A suppressed (exception) push or pop in the first cycle of a sequence still advances the FSM, so the sequence completes. In RET2, an underflowed second pop gives pc_load=0.
- Word order on the stack: low half is pushed first, high half second. RET pops the high half first, then the low half.
- sp arithmetic is unsigned ADDR_W bits. There is no wrap-around; the boundary rules above apply instead.

Test Plan:
- Reset, then PUSH alu_out=0xBEEF, then POP -> RAM[0x7FF]=0xBEEF; sp goes 0x7FF->0x7FE->0x7FF; rd_data=0xBEEF with rd_valid=1 one cycle after the pop.
- CALL at pc=0x0001_0010, then RET -> stack holds 0x0011 then 0x0001; sp returns to 0x7FF; pc_load=1 with pc_target=0x0001_0011 exactly one cycle after the second pop.
- INT with ccr=3'b101, pc=0x0000_0040, followed by RTI (is_rti=1) -> pc_target=0x0000_0040; pc_load and ccr_restore pulse together; ccr_frozen=3'b101.
- STD at addr 0x020, data 0x1234, then LDD 0x020 -> rd_data=0x1234. PUSH and STD asserted together -> only the push occurs; RAM[0x020] unchanged.
- Pop at sp=0x7FF -> stack_exc=1, sp stays 0x7FF, rd_valid=0. Fill to sp=0, then push -> stack_exc=1 and RAM[0] unchanged.
- call_phase=11 followed by a plain POP -> seq_err=1, FSM returns to IDLE, the pop executes. rst=0 asserted in RET2 -> no pc_load, sp=0x7FF.
